stack_file: RTL

//  Operand stack storage for the stack processor, the consumer of the stack-pointer ops.

---
 rtl/stack_file_pkg.sv | 22 ++
 rtl/stack_ptr.sv | 51 +++++
 rtl/stack_file.sv | 84 ++++++++
 3 files changed

// File: rtl/stack_file_pkg.sv
// Shared types for the operand stack: the stack op encoding and the per-op entry requirement.
package stack_file_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        ADV_1 = 2'b01,
        DES_1 = 2'b10,
        DES_2 = 2'b11
    } stk_op_t;

    // Minimum number of valid entries an op needs before it may touch cnt or storage.
    function automatic int unsigned min_entries(input stk_op_t op, input logic wr_en);
        unique case (op)
            HOLD:    return wr_en ? 32'd1 : 32'd0;
            ADV_1:   return 32'd0;
            DES_1:   return wr_en ? 32'd2 : 32'd1;
            DES_2:   return 32'd2;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_ptr.sv
// Stack depth counter: applies one op per clock, saturating at 0 and DEPTH,
// and reports whether the op is legal or raised an overflow/underflow event.
module stack_ptr
    import stack_file_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  stk_op_t       op,
    input  logic          wr_en,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty,
    output logic          legal,
    output logic          ovf_evt,
    output logic          unf_evt
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt   = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    always_comb begin
        ovf_evt = (op == ADV_1) && full;
        unf_evt = (op != ADV_1) && (32'(cnt_q) < min_entries(op, wr_en));
        legal   = !(ovf_evt || unf_evt);
        cnt_d   = cnt_q;
        if (legal) begin
            unique case (op)
                HOLD:  cnt_d = cnt_q;
                ADV_1: cnt_d = cnt_q + CW'(1);
                DES_1: cnt_d = cnt_q - CW'(1);
                DES_2: cnt_d = cnt_q - CW'(2);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stack_file.sv
// Operand stack for the stack processor: flop storage, TOS/NOS read ports,
// write-back index selection and sticky overflow/underflow flags.
module stack_file
    import stack_file_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  stk_op_t          op,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_err,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    cnt,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic             legal, ovf_evt, unf_evt, do_write;
    logic [AW-1:0]    wr_idx, tos_idx, nos_idx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             ovf_q, unf_q;

    stack_ptr #(
        .DEPTH(DEPTH)
    ) u_stack_ptr (
        .clk    (clk),
        .reset  (reset),
        .op     (op),
        .wr_en  (wr_en),
        .cnt    (cnt),
        .full   (full),
        .empty  (empty),
        .legal  (legal),
        .ovf_evt(ovf_evt),
        .unf_evt(unf_evt)
    );

    // Index is only meaningful once legal confirms enough entries exist.
    always_comb begin
        unique case (op)
            HOLD:    wr_idx = AW'(cnt - CW'(1));
            DES_1:   wr_idx = AW'(cnt - CW'(2));
            default: wr_idx = AW'(cnt);
        endcase
        do_write = reset && legal && ((op == ADV_1) || (wr_en && (op != DES_2)));
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign tos_idx = AW'(cnt - CW'(1));
    assign nos_idx = AW'(cnt - CW'(2));
    assign tos     = (cnt >= CW'(1)) ? mem[tos_idx] : '0;
    assign nos     = (cnt >= CW'(2)) ? mem[nos_idx] : '0;

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q && !clr_err) || ovf_evt;
            unf_q <= (unf_q && !clr_err) || unf_evt;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;

    op_known_a: assert property (@(posedge clk) disable iff (!reset) !$isunknown(op));

endmodule
